// File: rtl/handwrite_canvas.sv
// Mouse-driven handwriting canvas: saturating fixed-point cursor, gap-free
// stroke filling between successive cursor cells, and a registered crosshair overlay.
module handwrite_canvas #(
  parameter int GRID_W    = 30,
  parameter int GRID_H    = 30,
  parameter int FRAC_BITS = 9,
  parameter int CELL_PX   = 3,
  parameter int ORIGIN_X  = 537,
  parameter int ORIGIN_Y  = 276,
  parameter int ARM       = 5,
  parameter int COLOR_W   = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_mouse_valid,
  input  logic                        i_btn_left,
  input  logic                        i_btn_right,
  input  logic signed [8:0]           i_move_x,
  input  logic signed [8:0]           i_move_y,
  input  logic                        i_clear,
  input  logic                        i_ink_lock,
  input  logic [10:0]                 i_x,
  input  logic [10:0]                 i_y,
  input  logic [COLOR_W-1:0]          i_red,
  input  logic [COLOR_W-1:0]          i_green,
  input  logic [COLOR_W-1:0]          i_blue,
  output logic [COLOR_W-1:0]          o_red,
  output logic [COLOR_W-1:0]          o_green,
  output logic [COLOR_W-1:0]          o_blue,
  output logic [GRID_W*GRID_H-1:0]    o_canvas,
  output logic                        o_busy,
  output logic                        o_drop
);
  localparam int XLIM = GRID_W << FRAC_BITS;
  localparam int YLIM = GRID_H << FRAC_BITS;
  localparam int AXW  = $clog2(XLIM);
  localparam int AYW  = $clog2(YLIM);
  localparam int CW   = AXW - FRAC_BITS;
  localparam int RW   = AYW - FRAC_BITS;
  localparam int NC   = GRID_W * GRID_H;
  localparam int IW   = $clog2(NC);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q, state_d;
  logic [AXW-1:0]          cx_q, cx_d;
  logic [AYW-1:0]          cy_q, cy_d;
  logic [CW-1:0]           wc_q, wc_d, tc_q, tc_d;
  logic [RW-1:0]           wr_q, wr_d, tr_q, tr_d;
  logic                    val_q, val_d;
  logic [NC-1:0]           canvas_q, canvas_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    pend_paint_q, pend_paint_d;
  logic                    pend_val_q, pend_val_d;
  logic signed [8:0]       pend_mx_q, pend_mx_d, pend_my_q, pend_my_d;
  logic                    drop_q, drop_d;

  logic                    live_paint, take, pk_paint, pk_val;
  logic signed [8:0]       pk_mx, pk_my;
  logic [11:0]             pxc, pyc;
  logic                    hit;

  function automatic logic [AXW-1:0] sat_x(input logic [AXW-1:0] a, input logic signed [8:0] m);
    logic signed [AXW+1:0] s;
    s = $signed({2'b00, a}) + $signed({{(AXW-7){m[8]}}, m});
    if (s < 0)                                sat_x = '0;
    else if (s >= $signed((AXW+2)'(XLIM)))    sat_x = AXW'(XLIM - 1);
    else                                      sat_x = s[AXW-1:0];
  endfunction

  function automatic logic [AYW-1:0] sat_y(input logic [AYW-1:0] a, input logic signed [8:0] m);
    logic signed [AYW+1:0] s;
    s = $signed({2'b00, a}) + $signed({{(AYW-7){m[8]}}, m});
    if (s < 0)                                sat_y = '0;
    else if (s >= $signed((AYW+2)'(YLIM)))    sat_y = AYW'(YLIM - 1);
    else                                      sat_y = s[AYW-1:0];
  endfunction

  function automatic logic [CW-1:0] step_c(input logic [CW-1:0] w, input logic [CW-1:0] t);
    if (w < t)      step_c = w + CW'(1);
    else if (w > t) step_c = w - CW'(1);
    else            step_c = w;
  endfunction

  function automatic logic [RW-1:0] step_r(input logic [RW-1:0] w, input logic [RW-1:0] t);
    if (w < t)      step_r = w + RW'(1);
    else if (w > t) step_r = w - RW'(1);
    else            step_r = w;
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] c, input logic [RW-1:0] r);
    cell_idx = IW'(r) * IW'(GRID_W) + IW'(c);
  endfunction

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    wc_d         = wc_q;
    wr_d         = wr_q;
    tc_d         = tc_q;
    tr_d         = tr_q;
    val_d        = val_q;
    canvas_d     = canvas_q;
    pend_vld_d   = pend_vld_q;
    pend_paint_d = pend_paint_q;
    pend_val_d   = pend_val_q;
    pend_mx_d    = pend_mx_q;
    pend_my_d    = pend_my_q;
    drop_d       = 1'b0;
    take         = 1'b0;
    // Paint mode is fixed when the packet arrives, so a queued packet keeps it.
    live_paint   = (i_btn_left | i_btn_right) & ~i_ink_lock;
    pk_paint     = pend_vld_q ? pend_paint_q : live_paint;
    pk_val       = pend_vld_q ? pend_val_q   : i_btn_left;
    pk_mx        = pend_vld_q ? pend_mx_q    : i_move_x;
    pk_my        = pend_vld_q ? pend_my_q    : i_move_y;

    case (state_q)
      IDLE: begin
        take = pend_vld_q | i_mouse_valid;
        if (pend_vld_q) begin
          pend_vld_d   = i_mouse_valid;
          pend_paint_d = live_paint;
          pend_val_d   = i_btn_left;
          pend_mx_d    = i_move_x;
          pend_my_d    = i_move_y;
        end
        if (take) begin
          cx_d = sat_x(cx_q, pk_mx);
          cy_d = sat_y(cy_q, pk_my);
          if (pk_paint && !i_clear) begin
            wc_d    = cx_q[AXW-1:FRAC_BITS];
            wr_d    = cy_q[AYW-1:FRAC_BITS];
            tc_d    = cx_d[AXW-1:FRAC_BITS];
            tr_d    = cy_d[AYW-1:FRAC_BITS];
            val_d   = pk_val;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (i_mouse_valid) begin
          if (pend_vld_q) begin
            drop_d = 1'b1;
          end else begin
            pend_vld_d   = 1'b1;
            pend_paint_d = live_paint;
            pend_val_d   = i_btn_left;
            pend_mx_d    = i_move_x;
            pend_my_d    = i_move_y;
          end
        end
        if (i_clear) begin
          state_d = IDLE;
        end else begin
          canvas_d[cell_idx(wc_q, wr_q)] = val_q;
          if (wc_q == tc_q && wr_q == tr_q) begin
            state_d = IDLE;
          end else begin
            wc_d = step_c(wc_q, tc_q);
            wr_d = step_r(wr_q, tr_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_clear) canvas_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      canvas_q   <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      canvas_q   <= canvas_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    wc_q         <= wc_d;
    wr_q         <= wr_d;
    tc_q         <= tc_d;
    tr_q         <= tr_d;
    val_q        <= val_d;
    pend_paint_q <= pend_paint_d;
    pend_val_q   <= pend_val_d;
    pend_mx_q    <= pend_mx_d;
    pend_my_q    <= pend_my_d;
  end

  // Crosshair compares are widened to 13 bits so the +/-ARM window never wraps.
  always_comb begin
    pxc = 12'(ORIGIN_X) + 12'(cx_q[AXW-1:FRAC_BITS]) * 12'(CELL_PX);
    pyc = 12'(ORIGIN_Y) + 12'(cy_q[AYW-1:FRAC_BITS]) * 12'(CELL_PX);
    hit = (({1'b0, i_x} == pxc) &&
           ({2'b00, i_y} + 13'(ARM) >= {1'b0, pyc}) &&
           ({2'b00, i_y} <= {1'b0, pyc} + 13'(ARM))) ||
          (({1'b0, i_y} == pyc) &&
           ({2'b00, i_x} + 13'(ARM) >= {1'b0, pxc}) &&
           ({2'b00, i_x} <= {1'b0, pxc} + 13'(ARM)));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_red   <= hit ? '1 : i_red;
      o_green <= hit ? '1 : i_green;
      o_blue  <= hit ? '1 : i_blue;
    end
  end

  assign o_canvas = canvas_q;
  assign o_busy   = (state_q == FILL);
  assign o_drop   = drop_q;
endmodule

// File: tb/tb_handwrite_canvas.sv
// Randomised bench for handwrite_canvas against a stroke-list reference model.
module tb_handwrite_canvas;
  localparam int GW = 30, GH = 30, F = 9, CP = 3, OX = 537, OY = 276, ARMW = 5, CWID = 10;
  localparam int NC = GW * GH;

  logic              clk = 1'b0;
  logic              rst, strobe, bl, br, clr, lock;
  logic signed [8:0] mx, my;
  logic [10:0]       px, py;
  logic [CWID-1:0]   ir, ig, ib, or_, og, ob;
  logic [NC-1:0]     canvas;
  logic              busy, drop;

  handwrite_canvas dut (
    .i_clk(clk), .i_rst(rst), .i_mouse_valid(strobe), .i_btn_left(bl), .i_btn_right(br),
    .i_move_x(mx), .i_move_y(my), .i_clear(clr), .i_ink_lock(lock),
    .i_x(px), .i_y(py), .i_red(ir), .i_green(ig), .i_blue(ib),
    .o_red(or_), .o_green(og), .o_blue(ob), .o_canvas(canvas), .o_busy(busy), .o_drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {bit paint; bit val; int mx; int my;} pkt_t;
  typedef struct {int c; int r; bit v;} wr_t;

  int            n_vec = 0, n_mis = 0;
  int            mcx, mcy;
  logic [NC-1:0] mcan;
  wr_t           fq[$];
  bit            pv;
  pkt_t          pp;
  bit            exp_busy, exp_drop;
  logic [CWID-1:0] exp_r, exp_g, exp_b;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v >= lim) return lim - 1;
    return v;
  endfunction

  // A stroke of n = max(|dx|,|dy|) steps covers cells k = 0..n, each axis moving until it arrives.
  task automatic build_stroke(input int oc, input int orr, input int nc, input int nr, input bit v);
    int dx, dy, n, sx, sy;
    wr_t w;
    dx = nc - oc; dy = nr - orr;
    n  = (iabs(dx) > iabs(dy)) ? iabs(dx) : iabs(dy);
    sx = (dx > 0) ? 1 : (dx < 0) ? -1 : 0;
    sy = (dy > 0) ? 1 : (dy < 0) ? -1 : 0;
    for (int k = 0; k <= n; k++) begin
      w.c = oc + sx * ((k < iabs(dx)) ? k : iabs(dx));
      w.r = orr + sy * ((k < iabs(dy)) ? k : iabs(dy));
      w.v = v;
      fq.push_back(w);
    end
  endtask

  task automatic model_step();
    int pxc, pyc, ix, iy, oc, orr;
    bit hit, have;
    pkt_t live, p;
    wr_t w;
    pxc = OX + (mcx >> F) * CP;
    pyc = OY + (mcy >> F) * CP;
    ix = int'(px); iy = int'(py);
    hit = (ix == pxc && iabs(iy - pyc) <= ARMW) || (iy == pyc && iabs(ix - pxc) <= ARMW);
    exp_r = rst ? '0 : hit ? '1 : ir;
    exp_g = rst ? '0 : hit ? '1 : ig;
    exp_b = rst ? '0 : hit ? '1 : ib;
    exp_drop = 1'b0;
    if (rst) begin
      mcx = 0; mcy = 0; mcan = '0; fq.delete(); pv = 1'b0; exp_busy = 1'b0;
      return;
    end
    live.paint = (bl || br) && !lock;
    live.val   = bl;
    live.mx    = int'(mx);
    live.my    = int'(my);
    if (fq.size() == 0) begin
      have = 1'b0;
      if (pv) begin
        p = pp; have = 1'b1;
        if (strobe) pp = live; else pv = 1'b0;
      end else if (strobe) begin
        p = live; have = 1'b1;
      end
      if (have) begin
        oc = mcx >> F; orr = mcy >> F;
        mcx = clampi(mcx + p.mx, GW << F);
        mcy = clampi(mcy + p.my, GH << F);
        if (p.paint && !clr) build_stroke(oc, orr, mcx >> F, mcy >> F, p.val);
      end
    end else begin
      if (strobe) begin
        if (pv) exp_drop = 1'b1;
        else begin pp = live; pv = 1'b1; end
      end
      if (clr) fq.delete();
      else begin
        w = fq.pop_front();
        mcan[w.r * GW + w.c] = w.v;
      end
    end
    if (clr) mcan = '0;
    exp_busy = (fq.size() > 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("canvas", 1024'(canvas), 1024'(mcan));
    chk("busy",   1024'(busy),   1024'(exp_busy));
    chk("drop",   1024'(drop),   1024'(exp_drop));
    chk("red",    1024'(or_),    1024'(exp_r));
    chk("green",  1024'(og),     1024'(exp_g));
    chk("blue",   1024'(ob),     1024'(exp_b));
  endtask

  task automatic rand_pix();
    int pxc, pyc, ix, iy;
    pxc = OX + (mcx >> F) * CP;
    pyc = OY + (mcy >> F) * CP;
    case ($urandom_range(0, 3))
      0: begin ix = $urandom_range(0, 2047); iy = $urandom_range(0, 2047); end
      1: begin ix = pxc; iy = pyc + $urandom_range(0, 14) - 7; end
      2: begin iy = pyc; ix = pxc + $urandom_range(0, 14) - 7; end
      default: begin ix = pxc + $urandom_range(0, 14) - 7; iy = pyc + $urandom_range(0, 14) - 7; end
    endcase
    px = 11'(ix); py = 11'(iy);
    ir = 10'($urandom); ig = 10'($urandom); ib = 10'($urandom);
  endtask

  task automatic pkt(input bit l, input bit r, input int dx, input int dy, input int gap);
    strobe = 1'b1; bl = l; br = r; mx = 9'(dx); my = 9'(dy);
    rand_pix();
    tick();
    strobe = 1'b0;
    for (int i = 0; i < gap; i++) begin rand_pix(); tick(); end
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; bl = 1'b0; br = 1'b0; clr = 1'b0; lock = 1'b0;
    mx = '0; my = '0; px = '0; py = '0; ir = '0; ig = '0; ib = '0;
    mcx = 0; mcy = 0; mcan = '0; pv = 1'b0;
    tick(); tick();
    rst = 1'b0;
    px = 11'd537; py = 11'd276; ir = 10'h155; ig = 10'h155; ib = 10'h155;
    tick();
    py = 11'd282;
    tick();
    px = 11'd542; py = 11'd276;
    tick();

    // Ink stroke rightwards in half-cell packets, then a diagonal.
    for (int i = 0; i < 6; i++) pkt(1'b1, 1'b0, 255, 0, 3);
    for (int i = 0; i < 4; i++) pkt(1'b1, 1'b0, 255, 200, 3);
    // Left beats right when both are held.
    for (int i = 0; i < 3; i++) pkt(1'b1, 1'b1, 0, 255, 3);
    // Erase back over the inked path.
    for (int i = 0; i < 10; i++) pkt(1'b0, 1'b1, -255, -100, 3);
    // Saturation at both ends of both axes.
    for (int i = 0; i < 80; i++) pkt(1'b0, 1'b0, -256, -256, 0);
    for (int i = 0; i < 70; i++) pkt(1'b0, 1'b0, 255, 255, 0);
    for (int i = 0; i < 4; i++) pkt(1'b1, 1'b0, 255, 255, 2);
    // Back-to-back strobes: one queues, the rest drop.
    for (int i = 0; i < 5; i++) pkt(1'b1, 1'b0, -255, -255, 0);
    for (int i = 0; i < 5; i++) begin rand_pix(); tick(); end
    // Clear in the middle of a fill.
    pkt(1'b1, 1'b0, -255, 0, 0);
    clr = 1'b1; rand_pix(); tick(); clr = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_pix(); tick(); end
    // Ink lock moves the cursor without painting.
    lock = 1'b1;
    for (int i = 0; i < 6; i++) pkt(1'b1, 1'b0, -255, -200, 2);
    lock = 1'b0;
    // Reset in the middle of a fill.
    pkt(1'b1, 1'b0, 255, 255, 0);
    rst = 1'b1; rand_pix(); tick(); rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      int dx, dy;
      rst    = ($urandom_range(0, 799) == 0);
      clr    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) lock = ~lock;
      strobe = ($urandom_range(0, 1) == 0);
      bl     = ($urandom_range(0, 2) != 0);
      br     = ($urandom_range(0, 1) == 0);
      dx     = $urandom_range(0, 511) - 256 + ((i / 500) % 2 == 0 ? 60 : -60);
      dy     = $urandom_range(0, 511) - 256 + ((i / 700) % 2 == 0 ? 60 : -60);
      mx     = 9'(clampi(dx + 256, 512) - 256);
      my     = 9'(clampi(dy + 256, 512) - 256);
      rand_pix();
      tick();
    end
    rst = 1'b0; strobe = 1'b0; clr = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_pix(); tick(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
